// File: rtl/sq_sum_if.sv
// sq_sum operand/result bundle.
// Slave side is the unit, master side the requester.
interface sq_sum_if;
  logic [7:0]  a_bi;
  logic [7:0]  b_bi;
  logic        start_i;
  logic        busy_o;
  logic        valid_o;
  logic [7:0]  y_bo;
  logic [16:0] sum_bo;
  logic        ovf_o;

  modport slave (
    input  a_bi,
    input  b_bi,
    input  start_i,
    output busy_o,
    output valid_o,
    output y_bo,
    output sum_bo,
    output ovf_o
  );

  modport master (
    output a_bi,
    output b_bi,
    output start_i,
    input  busy_o,
    input  valid_o,
    input  y_bo,
    input  sum_bo,
    input  ovf_o
  );
endinterface

// File: rtl/sq_sum.sv
// Sum of squares a*a + b*b on one bit-serial
// shift-add multiplier, 17-cycle fixed latency.
module sq_sum (
  input  logic     clk_i,
  input  logic     rst_i,
  sq_sum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL_A,
    MUL_B,
    ADD
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  cnt;
  logic [15:0] acc;
  logic [15:0] sq_a;

  logic        busy_q;
  logic        valid_q;
  logic [7:0]  y_q;
  logic [16:0] sum_q;
  logic        ovf_q;

  logic        accept;
  logic        finish;
  logic        last;
  logic [7:0]  mcand;
  logic [15:0] addend;
  logic [15:0] prod;
  logic [16:0] sum_nx;
  logic        sat;

  // shared multiplier datapath: one operand bit per cycle
  always_comb begin
    mcand  = (state == MUL_B) ? b_q : a_q;
    addend = '0;
    if (mcand[cnt])
      addend = {8'd0, mcand} << cnt;
    prod   = acc + addend;
    last   = (cnt == 3'd7);
    sum_nx = {1'b0, sq_a} + {1'b0, acc};
    sat    = |sum_nx[16:8];
  end

  // next-state and control strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          accept   = 1'b1;
          state_nx = MUL_A;
        end
      end
      MUL_A: begin
        if (last)
          state_nx = MUL_B;
      end
      MUL_B: begin
        if (last)
          state_nx = ADD;
      end
      ADD: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // operand capture, bit counter and accumulators
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      acc  <= '0;
      sq_a <= '0;
    end else if (accept) begin
      a_q <= bus.a_bi;
      b_q <= bus.b_bi;
      cnt <= '0;
      acc <= '0;
    end else if (state == MUL_A) begin
      cnt <= cnt + 3'd1;
      if (last) begin
        sq_a <= prod;
        acc  <= '0;
      end else begin
        acc <= prod;
      end
    end else if (state == MUL_B) begin
      cnt <= cnt + 3'd1;
      acc <= prod;
    end
  end

  // registered status and held results
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q  <= (state_nx != IDLE);
      valid_q <= finish;
      if (finish) begin
        sum_q <= sum_nx;
        y_q   <= sat ? 8'hFF : sum_nx[7:0];
        ovf_q <= sat;
      end
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.y_bo    = y_q;
  assign bus.sum_bo  = sum_q;
  assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_sq_sum.sv
// Directed bench for sq_sum: latency, saturation,
// start-while-busy, back-to-back and mid-op reset.
module tb_sq_sum;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sq_sum_if bus ();

  sq_sum dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp_v);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [16:0] es,
                       input logic [7:0] ey,
                       input logic eo);
    int bc;
    int vc;
    bc = 0;
    vc = 0;
    @(negedge clk);
    bus.a_bi    = a;
    bus.b_bi    = b;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.a_bi    = ~a;
    bus.b_bi    = ~b;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (bus.busy_o) bc++;
      if (bus.valid_o) vc++;
    end
    chk({tag, "_busy_cycles"}, bc, 17);
    chk({tag, "_early_valid"}, vc, 0);
    @(negedge clk);
    chk({tag, "_valid"}, bus.valid_o, 1);
    chk({tag, "_busy_fall"}, bus.busy_o, 0);
    chk({tag, "_sum"}, bus.sum_bo, es);
    chk({tag, "_y"}, bus.y_bo, ey);
    chk({tag, "_ovf"}, bus.ovf_o, eo);
    @(negedge clk);
    chk({tag, "_valid_drop"}, bus.valid_o, 0);
    chk({tag, "_y_hold"}, bus.y_bo, ey);
  endtask

  initial begin
    int bad;
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.a_bi    = 8'd0;
    bus.b_bi    = 8'd0;
    bus.start_i = 1'b0;

    #12;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_y", bus.y_bo, 0);
    chk("rst_sum", bus.sum_bo, 0);
    chk("rst_ovf", bus.ovf_o, 0);

    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy_o || bus.valid_o ||
          bus.y_bo != 0 || bus.sum_bo != 0 ||
          bus.ovf_o)
        bad++;
    end
    chk("idle_quiet", bad, 0);

    do_op("basic", 8'd3, 8'd4, 17'd25, 8'd25, 1'b0);
    do_op("zero", 8'd0, 8'd0, 17'd0, 8'd0, 1'b0);
    do_op("k242", 8'd11, 8'd11, 17'd242, 8'd242, 1'b0);
    do_op("k274", 8'd15, 8'd7, 17'd274, 8'd255, 1'b1);
    do_op("max", 8'd255, 8'd255, 17'd130050,
          8'd255, 1'b1);
    do_op("asym", 8'd200, 8'd1, 17'd40001,
          8'd255, 1'b1);

    // start while busy
    @(negedge clk);
    bus.a_bi    = 8'd3;
    bus.b_bi    = 8'd4;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.a_bi    = 8'd9;
    bus.b_bi    = 8'd9;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.a_bi    = 8'd200;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("sb_e16_valid", bus.valid_o, 0);
    chk("sb_e16_busy", bus.busy_o, 1);
    @(negedge clk);
    chk("sb_valid", bus.valid_o, 1);
    chk("sb_busy_fall", bus.busy_o, 0);
    chk("sb_sum", bus.sum_bo, 25);
    chk("sb_y", bus.y_bo, 25);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy_o || bus.valid_o) bad++;
    end
    chk("sb_no_second", bad, 0);

    // back-to-back with start held
    @(negedge clk);
    bus.a_bi    = 8'd5;
    bus.b_bi    = 8'd12;
    bus.start_i = 1'b1;
    @(posedge clk);
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk("b2b_v1", bus.valid_o, 1);
    chk("b2b_y1", bus.y_bo, 169);
    chk("b2b_gap", bus.busy_o, 0);
    @(negedge clk);
    chk("b2b_reaccept", bus.busy_o, 1);
    chk("b2b_v1_drop", bus.valid_o, 0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("b2b_e34_valid", bus.valid_o, 0);
    @(negedge clk);
    chk("b2b_v2", bus.valid_o, 1);
    chk("b2b_y2", bus.y_bo, 169);
    chk("b2b_sum2", bus.sum_bo, 169);
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("b2b_stop", bus.busy_o, 0);

    // reset in the middle of an operation
    @(negedge clk);
    bus.a_bi    = 8'd6;
    bus.b_bi    = 8'd8;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_busy", bus.busy_o, 0);
    chk("mr_valid", bus.valid_o, 0);
    chk("mr_y", bus.y_bo, 0);
    chk("mr_sum", bus.sum_bo, 0);
    chk("mr_ovf", bus.ovf_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.busy_o || bus.valid_o) bad++;
    end
    chk("mr_no_valid", bad, 0);
    do_op("post_rst", 8'd6, 8'd8, 17'd100,
          8'd100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sq_sum.md
# sq_sum

Sequential sum-of-squares unit computing s = a² + b² over two unsigned 8-bit operands using a single shared shift-add multiplier. It is the front half of the hypotenuse datapath. Its saturated 8-bit result and one-cycle `valid_o` pulse drive the `x_bi`/`start_i` inputs of the downstream `sqrt` stage directly. It also exposes the full-width sum for checking and for wider consumers.

## Interface
- No parameters; all widths are fixed.
- `clk_i` input 1: the single clock; all state updates on its rising edge.
- `rst_i` input 1: reset, asynchronous and active-low.
- `a_bi` input 8: operand a, unsigned; sampled only when a start is accepted.
- `b_bi` input 8: operand b, unsigned; sampled only when a start is accepted.
- `start_i` input 1: request a new operation; honoured only in IDLE.
- `busy_o` output 1: high while an operation is in progress (state ≠ IDLE).
- `valid_o` output 1: one-cycle pulse when a new result is written.
- `y_bo` output 8: saturated result, min(a²+b², 255).
- `sum_bo` output 17: exact a²+b²; maximum value 130050.
- `ovf_o` output 1: set when a²+b² > 255; holds until the next result.

## Operation
- States and transitions:
  - IDLE: on `start_i`=1, capture `a_bi` and `b_bi`, clear the accumulator and bit counter, then go to MUL_A.
  - MUL_A: for 8 cycles, if multiplier bit[i]=1, add (a << i) into a 16-bit partial product. After the 8th cycle, store a² and go to MUL_B.
  - MUL_B: same 8-cycle algorithm on b, reusing the same adder and counter. Go to ADD.
  - ADD: compute the 17-bit sum a²+b². Write `sum_bo`. Write `y_bo` as the saturated value. Write `ovf_o` = (sum > 255). Pulse `valid_o`. Go to IDLE.
- Bit-serial multiplication: exactly one multiplier bit per cycle, with no early termination for zero operands. Latency is therefore data-independent.
- `start_i` is ignored in MUL_A, MUL_B and ADD. Operands captured at accept are not affected by later changes to `a_bi`/`b_bi`.
- `y_bo`, `sum_bo` and `ovf_o` hold their values between operations. They change only in ADD or on reset.
- All arithmetic is unsigned. Intermediates are 16 bits per square and 17 bits for the sum, so no internal wrap occurs.
- Reset at any time, including mid-operation, forces the following:
  - state IDLE
  - `busy_o`=0, `valid_o`=0, `y_bo`=0, `sum_bo`=0, `ovf_o`=0
  - counter and accumulators cleared
  
  The in-flight operation is discarded and produces no `valid_o`.

## Timing
- Edge E0 samples `start_i`=1 in IDLE. `busy_o` rises after E0.
- E1–E8 run the MUL_A iterations; E9–E16 run the MUL_B iterations.
- At E17 (the ADD state), the outputs update, `valid_o` rises and `busy_o` falls.
- Results are available 17 cycles after acceptance. `busy_o` is high for exactly 17 cycles. `valid_o` is high for exactly 1 cycle (E17→E18).
- The earliest next accept is at E18. With `start_i` held high, operations repeat every 18 cycles.
- `busy_o` and `valid_o` are registered outputs with no combinational path from `start_i`.
- `valid_o` may drive `sqrt.start_i`: `y_bo` is stable on the same edge at which `sqrt` samples it.
- Reset deassertion is asynchronous. The first accept is possible on the first rising edge after `rst_i` goes high.

## Test plan
- Reset: assert `rst_i`=0 -> `busy_o`=0, `valid_o`=0, `y_bo`=0, `sum_bo`=0, `ovf_o`=0. Release and hold `start_i`=0 for 20 cycles -> outputs unchanged.
- Basic case, a=3, b=4, one-cycle start: `busy_o` is high for 17 cycles; at E17 `sum_bo`=25, `y_bo`=25, `ovf_o`=0, and `valid_o` is a single-cycle pulse.
- Zero and saturation boundaries:
  - a=0, b=0 -> 0, `ovf_o`=0.
  - a=11, b=11 -> 242, `ovf_o`=0.
  - a=15, b=7 -> `sum_bo`=274, `y_bo`=255, `ovf_o`=1.
  - a=255, b=255 -> `sum_bo`=130050, `y_bo`=255, `ovf_o`=1.
  
  All four complete with 17-cycle latency.
- Start while busy: accept a=3, b=4. Pulse `start_i` with a=9, b=9 at E5. Change `a_bi` during operation -> result is 25. No second operation starts, and `busy_o` still falls at E17.
- Back-to-back: hold `start_i`=1 with a=5, b=12. The second accept occurs at E18, and `valid_o` pulses at E17 and E35 with `y_bo`=169 each time.
- Reset mid-operation: assert `rst_i`=0 at E9 -> all outputs clear immediately and no `valid_o` pulse occurs. A fresh a=6, b=8 then yields `y_bo`=100 after 17 cycles.
